// File: rtl/regfile_wb_scheduler_pkg.sv
// Shared constants and types for the register-file write-back scheduler.
// Holds the reset/write-enable encodings and the two-way grant encoding
// used by the top and by the optional round-robin arbiter
// (build macro REGWB_RR_ARB_EN selects round-robin tie-breaking).
package regfile_wb_scheduler_pkg;

   // Synchronous reset is active-low.
   localparam logic RST_ENABLE    = 1'b0;
   localparam logic RST_DISABLE   = 1'b1;

   // Write-port enable encoding.
   localparam logic WRITE_ENABLE  = 1'b1;
   localparam logic WRITE_DISABLE = 1'b0;

   // Grant / source-select encoding: A is the ALU path, B the load path.
   typedef enum logic {
      WB_SEL_A = 1'b0,
      WB_SEL_B = 1'b1
   } wb_sel_e;

endpackage

// File: rtl/regfile_wb_scheduler_wb_rr_arbiter.sv
// Two-way round-robin grant for the write-back port (module wb_rr_arbiter).
// Instantiated by the top only when REGWB_RR_ARB_EN is defined. On a tie
// the requester that did not win the last accepted transfer is granted;
// lastGrant moves only when a transfer is accepted.
module wb_rr_arbiter
   import regfile_wb_scheduler_pkg::*;
(
   input  logic clk_in,
   input  logic rst_in,
   input  logic a_valid_i,
   input  logic b_valid_i,
   output logic a_ready_o,
   output logic b_ready_o
);

   wb_sel_e last_grant_q;
   wb_sel_e last_grant_d;

   // Grant decode from valids and the last winner.
   always_comb begin
      a_ready_o = 1'b0;
      b_ready_o = 1'b0;
      if (a_valid_i && b_valid_i) begin
         if (last_grant_q == WB_SEL_B) begin
            a_ready_o = 1'b1;
         end else begin
            b_ready_o = 1'b1;
         end
      end else if (a_valid_i) begin
         a_ready_o = 1'b1;
      end else if (b_valid_i) begin
         b_ready_o = 1'b1;
      end else begin
         a_ready_o = 1'b0;
         b_ready_o = 1'b0;
      end
   end

   // Remember the winner of an accepted transfer; hold otherwise.
   always_comb begin
      last_grant_d = last_grant_q;
      if (a_ready_o) begin
         last_grant_d = WB_SEL_A;
      end else if (b_ready_o) begin
         last_grant_d = WB_SEL_B;
      end else begin
         last_grant_d = last_grant_q;
      end
   end

   // lastGrant register; reset to B so A wins the first tie.
   always_ff @(posedge clk_in) begin
      if (rst_in == RST_ENABLE) begin
         last_grant_q <= WB_SEL_B;
      end else begin
         last_grant_q <= last_grant_d;
      end
   end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Write-back scheduler for the register file's single write port.
// Arbitrates ALU (A) and load (B) write-back requesters, registers the
// winning entry onto the RegFile write port, and keeps a per-register
// pending-write scoreboard for decode hazard stalls.
// Build macro REGWB_RR_ARB_EN: defined -> round-robin tie-break via
// wb_rr_arbiter; undefined -> fixed priority, B wins every tie.
module regfile_wb_scheduler
   import regfile_wb_scheduler_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int IDX_W  = 5
) (
   input  logic              clk_in,
   input  logic              rst_in,
   input  logic              flush_in,
   input  logic              issueE_in,
   input  logic [IDX_W-1:0]  issueIdx_in,
   output logic              issueReady_out,
   input  logic              aValid_in,
   input  logic [IDX_W-1:0]  aIdx_in,
   input  logic [DATA_W-1:0] aData_in,
   output logic              aReady_out,
   input  logic              bValid_in,
   input  logic [IDX_W-1:0]  bIdx_in,
   input  logic [DATA_W-1:0] bData_in,
   output logic              bReady_out,
   output logic              writeE_out,
   output logic [IDX_W-1:0]  writeIdx_out,
   output logic [DATA_W-1:0] writeData_out,
   input  logic [IDX_W-1:0]  reg1Idx_in,
   input  logic [IDX_W-1:0]  reg2Idx_in,
   output logic              reg1Busy_out,
   output logic              reg2Busy_out
);

   localparam int NUM_REGS = 1 << IDX_W;

   // Grant / accepted entry
   logic              a_ready_s;
   logic              b_ready_s;
   logic              acc_s;
   wb_sel_e           acc_sel_s;
   logic [IDX_W-1:0]  acc_idx_s;
   logic [DATA_W-1:0] acc_data_s;

   // Registered write port
   logic              write_e_q;
   logic              write_e_d;
   logic [IDX_W-1:0]  write_idx_q;
   logic [IDX_W-1:0]  write_idx_d;
   logic [DATA_W-1:0] write_data_q;
   logic [DATA_W-1:0] write_data_d;

   // Scoreboard
   logic [NUM_REGS-1:0] busy_q;
   logic [NUM_REGS-1:0] busy_d;
   logic [NUM_REGS-1:0] commit_mask_s;
   logic [NUM_REGS-1:0] set_mask_s;
   logic [NUM_REGS-1:0] busy_vis_s;
   logic                issue_ready_s;

`ifdef REGWB_RR_ARB_EN
   wb_rr_arbiter u_arb (
      .clk_in    (clk_in),
      .rst_in    (rst_in),
      .a_valid_i (aValid_in),
      .b_valid_i (bValid_in),
      .a_ready_o (a_ready_s),
      .b_ready_o (b_ready_s)
   );
`else
   // Fixed priority: the load path (B) always wins a tie.
   always_comb begin
      a_ready_s = 1'b0;
      b_ready_s = 1'b0;
      if (bValid_in) begin
         b_ready_s = 1'b1;
      end else if (aValid_in) begin
         a_ready_s = 1'b1;
      end else begin
         a_ready_s = 1'b0;
         b_ready_s = 1'b0;
      end
   end
`endif

   assign aReady_out = a_ready_s;
   assign bReady_out = b_ready_s;

   // Select the accepted entry; at most one ready is ever high.
   always_comb begin
      acc_s     = a_ready_s | b_ready_s;
      acc_sel_s = b_ready_s ? WB_SEL_B : WB_SEL_A;
      case (acc_sel_s)
         WB_SEL_A: begin
            acc_idx_s  = aIdx_in;
            acc_data_s = aData_in;
         end
         WB_SEL_B: begin
            acc_idx_s  = bIdx_in;
            acc_data_s = bData_in;
         end
         default: begin
            acc_idx_s  = {IDX_W{1'b0}};
            acc_data_s = {DATA_W{1'b0}};
         end
      endcase
   end

   // Next write-port contents; idx 0 entries are consumed without a write.
   always_comb begin
      write_e_d    = WRITE_DISABLE;
      write_idx_d  = write_idx_q;
      write_data_d = write_data_q;
      if (acc_s && (acc_idx_s != {IDX_W{1'b0}})) begin
         write_e_d    = WRITE_ENABLE;
         write_idx_d  = acc_idx_s;
         write_data_d = acc_data_s;
      end else begin
         write_e_d    = WRITE_DISABLE;
         write_idx_d  = write_idx_q;
         write_data_d = write_data_q;
      end
   end

   // Write-port register; reset drops any in-flight entry.
   always_ff @(posedge clk_in) begin
      if (rst_in == RST_ENABLE) begin
         write_e_q    <= WRITE_DISABLE;
         write_idx_q  <= {IDX_W{1'b0}};
         write_data_q <= {DATA_W{1'b0}};
      end else begin
         write_e_q    <= write_e_d;
         write_idx_q  <= write_idx_d;
         write_data_q <= write_data_d;
      end
   end

   assign writeE_out    = write_e_q;
   assign writeIdx_out  = write_idx_q;
   assign writeData_out = write_data_q;

   // Visible busy: the write now on the port is seen via the RegFile bypass.
   always_comb begin
      commit_mask_s = {NUM_REGS{1'b0}};
      if (write_e_q == WRITE_ENABLE) begin
         commit_mask_s = {{(NUM_REGS-1){1'b0}}, 1'b1} << write_idx_q;
      end else begin
         commit_mask_s = {NUM_REGS{1'b0}};
      end
      busy_vis_s    = busy_q & ~commit_mask_s;
      issue_ready_s = ~busy_vis_s[issueIdx_in];
   end

   assign issueReady_out = issue_ready_s;
   assign reg1Busy_out   = busy_vis_s[reg1Idx_in];
   assign reg2Busy_out   = busy_vis_s[reg2Idx_in];

   // Scoreboard next state: flush beats everything, issue-set beats commit-clear.
   always_comb begin
      set_mask_s = {NUM_REGS{1'b0}};
      if (issueE_in && issue_ready_s && (issueIdx_in != {IDX_W{1'b0}})) begin
         set_mask_s = {{(NUM_REGS-1){1'b0}}, 1'b1} << issueIdx_in;
      end else begin
         set_mask_s = {NUM_REGS{1'b0}};
      end
      busy_d = {NUM_REGS{1'b0}};
      if (flush_in) begin
         busy_d = {NUM_REGS{1'b0}};
      end else begin
         busy_d    = (busy_q & ~commit_mask_s) | set_mask_s;
         busy_d[0] = 1'b0;
      end
   end

   // Scoreboard register.
   always_ff @(posedge clk_in) begin
      if (rst_in == RST_ENABLE) begin
         busy_q <= {NUM_REGS{1'b0}};
      end else begin
         busy_q <= busy_d;
      end
   end

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Self-checking bench for regfile_wb_scheduler: directed vector table,
// hand sequences for tie/flush/reset corners, and a randomized phase
// against a behavioural model. Honours REGWB_RR_ARB_EN for tie expectations.
module tb_regfile_wb_scheduler;

   localparam int DW = 32;
   localparam int IW = 5;
   localparam int NR = 32;

   logic          clk_in = 1'b0;
   logic          rst_in;
   logic          flush_in;
   logic          issueE_in;
   logic [IW-1:0] issueIdx_in;
   logic          issueReady_out;
   logic          aValid_in;
   logic [IW-1:0] aIdx_in;
   logic [DW-1:0] aData_in;
   logic          aReady_out;
   logic          bValid_in;
   logic [IW-1:0] bIdx_in;
   logic [DW-1:0] bData_in;
   logic          bReady_out;
   logic          writeE_out;
   logic [IW-1:0] writeIdx_out;
   logic [DW-1:0] writeData_out;
   logic [IW-1:0] reg1Idx_in;
   logic [IW-1:0] reg2Idx_in;
   logic          reg1Busy_out;
   logic          reg2Busy_out;

   int checks = 0;
   int errors = 0;

   always #5 clk_in = ~clk_in;

   regfile_wb_scheduler #(.DATA_W(DW), .IDX_W(IW)) dut (
      .clk_in(clk_in), .rst_in(rst_in), .flush_in(flush_in),
      .issueE_in(issueE_in), .issueIdx_in(issueIdx_in), .issueReady_out(issueReady_out),
      .aValid_in(aValid_in), .aIdx_in(aIdx_in), .aData_in(aData_in), .aReady_out(aReady_out),
      .bValid_in(bValid_in), .bIdx_in(bIdx_in), .bData_in(bData_in), .bReady_out(bReady_out),
      .writeE_out(writeE_out), .writeIdx_out(writeIdx_out), .writeData_out(writeData_out),
      .reg1Idx_in(reg1Idx_in), .reg2Idx_in(reg2Idx_in),
      .reg1Busy_out(reg1Busy_out), .reg2Busy_out(reg2Busy_out)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   bit          m_busy[NR];
   bit          m_we;
   logic [4:0]  m_widx;
   logic [31:0] m_wdata;
   bit          m_last_b;

   function automatic void model_reset();
      for (int i = 0; i < NR; i++) m_busy[i] = 1'b0;
      m_we = 1'b0; m_widx = '0; m_wdata = '0; m_last_b = 1'b1;
   endfunction

   function automatic bit m_visible_busy(input logic [4:0] i);
      return m_busy[i] && !(m_we && m_widx == i);
   endfunction

   function automatic void m_grant(output bit ga, output bit gb);
      if (aValid_in && bValid_in) begin
`ifdef REGWB_RR_ARB_EN
         ga = m_last_b; gb = !m_last_b;
`else
         ga = 1'b0; gb = 1'b1;
`endif
      end else begin
         ga = aValid_in; gb = bValid_in;
      end
   endfunction

   function automatic void model_step();
      bit ga, gb;
      bit nb[NR];
      logic [4:0] idx;
      m_grant(ga, gb);
      for (int i = 0; i < NR; i++) nb[i] = m_busy[i];
      if (m_we) nb[m_widx] = 1'b0;
      if (issueE_in && issueIdx_in != 0 && !m_visible_busy(issueIdx_in)) nb[issueIdx_in] = 1'b1;
      if (flush_in) for (int i = 0; i < NR; i++) nb[i] = 1'b0;
      for (int i = 0; i < NR; i++) m_busy[i] = nb[i];
      if (ga || gb) begin
         idx = ga ? aIdx_in : bIdx_in;
         m_last_b = gb;
         if (idx != 0) begin
            m_we = 1'b1; m_widx = idx; m_wdata = ga ? aData_in : bData_in;
         end else begin
            m_we = 1'b0;
         end
      end else begin
         m_we = 1'b0;
      end
   endfunction

   task automatic check_model();
      bit ga, gb;
      m_grant(ga, gb);
      chk("rnd_aReady", aReady_out, ga);
      chk("rnd_bReady", bReady_out, gb);
      chk("rnd_writeE", writeE_out, m_we);
      if (m_we) begin
         chk("rnd_writeIdx", writeIdx_out, m_widx);
         chk("rnd_writeData", writeData_out, m_wdata);
      end
      chk("rnd_reg1Busy", reg1Busy_out, m_visible_busy(reg1Idx_in));
      chk("rnd_reg2Busy", reg2Busy_out, m_visible_busy(reg2Idx_in));
      chk("rnd_issueReady", issueReady_out, !m_visible_busy(issueIdx_in));
   endtask

   // ---------------- helpers ----------------
   task automatic idle();
      flush_in = 1'b0; issueE_in = 1'b0; issueIdx_in = '0;
      aValid_in = 1'b0; aIdx_in = '0; aData_in = '0;
      bValid_in = 1'b0; bIdx_in = '0; bData_in = '0;
      reg1Idx_in = '0; reg2Idx_in = '0;
   endtask

   task automatic next_cycle();
      @(posedge clk_in);
      #1;
   endtask

   task automatic do_reset();
      idle();
      rst_in = 1'b0;
      next_cycle();
      rst_in = 1'b1;
   endtask

   typedef struct {
      logic av; logic [4:0] aidx; logic [31:0] adata;
      logic bv; logic [4:0] bidx; logic [31:0] bdata;
      logic ie; logic [4:0] iidx; logic [4:0] r;
      logic e_ardy; logic e_brdy; logic e_we; logic [4:0] e_widx; logic [31:0] e_wdata;
      logic e_busy; logic e_irdy;
   } vec_t;

   vec_t vec[16];

   initial begin
      // av aidx adata  bv bidx bdata  ie iidx r  ardy brdy we widx wdata busy irdy
      vec[0]  = '{1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0,    1'b0, 1'b1};
      vec[1]  = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 5'd5, 1'b0, 1'b0, 1'b1, 5'd5, 32'h1234, 1'b0, 1'b1};
      vec[2]  = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,    1'b1, 5'd7, 5'd7, 1'b0, 1'b0, 1'b0, 5'd5, 32'h1234, 1'b0, 1'b1};
      vec[3]  = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,    1'b0, 5'd7, 5'd7, 1'b0, 1'b0, 1'b0, 5'd5, 32'h1234, 1'b1, 1'b0};
      vec[4]  = '{1'b0, 5'd0, 32'h0,    1'b1, 5'd7, 32'hBEEF, 1'b0, 5'd7, 5'd7, 1'b0, 1'b1, 1'b0, 5'd5, 32'h1234, 1'b1, 1'b0};
      vec[5]  = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,    1'b0, 5'd7, 5'd7, 1'b0, 1'b0, 1'b1, 5'd7, 32'hBEEF, 1'b0, 1'b1};
      vec[6]  = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,    1'b0, 5'd7, 5'd7, 1'b0, 1'b0, 1'b0, 5'd7, 32'hBEEF, 1'b0, 1'b1};
      vec[7]  = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,    1'b1, 5'd3, 5'd3, 1'b0, 1'b0, 1'b0, 5'd7, 32'hBEEF, 1'b0, 1'b1};
      vec[8]  = '{1'b1, 5'd3, 32'h33,   1'b0, 5'd0, 32'h0,    1'b0, 5'd3, 5'd3, 1'b1, 1'b0, 1'b0, 5'd7, 32'hBEEF, 1'b1, 1'b0};
      vec[9]  = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,    1'b1, 5'd3, 5'd3, 1'b0, 1'b0, 1'b1, 5'd3, 32'h33,   1'b0, 1'b1};
      vec[10] = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,    1'b0, 5'd3, 5'd3, 1'b0, 1'b0, 1'b0, 5'd3, 32'h33,   1'b1, 1'b0};
      vec[11] = '{1'b1, 5'd0, 32'hAA,   1'b0, 5'd0, 32'h0,    1'b0, 5'd3, 5'd3, 1'b1, 1'b0, 1'b0, 5'd3, 32'h33,   1'b1, 1'b0};
      vec[12] = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,    1'b0, 5'd3, 5'd3, 1'b0, 1'b0, 1'b0, 5'd3, 32'h33,   1'b1, 1'b0};
      vec[13] = '{1'b0, 5'd0, 32'h0,    1'b1, 5'd3, 32'h44,   1'b0, 5'd3, 5'd3, 1'b0, 1'b1, 1'b0, 5'd3, 32'h33,   1'b1, 1'b0};
      vec[14] = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,    1'b0, 5'd3, 5'd3, 1'b0, 1'b0, 1'b1, 5'd3, 32'h44,   1'b0, 1'b1};
      vec[15] = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,    1'b0, 5'd3, 5'd3, 1'b0, 1'b0, 1'b0, 5'd3, 32'h44,   1'b0, 1'b1};

      idle();
      rst_in = 1'b1;
      #1;
      do_reset();

      // Reset state
      #3;
      chk("rst_writeE", writeE_out, 1'b0);
      chk("rst_writeIdx", writeIdx_out, 5'd0);
      chk("rst_writeData", writeData_out, 32'h0);
      chk("rst_aReady", aReady_out, 1'b0);
      chk("rst_bReady", bReady_out, 1'b0);
      chk("rst_issueReady", issueReady_out, 1'b1);
      next_cycle();

      // Directed vector table
      for (int k = 0; k < 16; k++) begin
         aValid_in = vec[k].av; aIdx_in = vec[k].aidx; aData_in = vec[k].adata;
         bValid_in = vec[k].bv; bIdx_in = vec[k].bidx; bData_in = vec[k].bdata;
         issueE_in = vec[k].ie; issueIdx_in = vec[k].iidx;
         reg1Idx_in = vec[k].r; reg2Idx_in = vec[k].r;
         #3;
         chk($sformatf("vec%0d_aReady", k), aReady_out, vec[k].e_ardy);
         chk($sformatf("vec%0d_bReady", k), bReady_out, vec[k].e_brdy);
         chk($sformatf("vec%0d_writeE", k), writeE_out, vec[k].e_we);
         chk($sformatf("vec%0d_writeIdx", k), writeIdx_out, vec[k].e_widx);
         chk($sformatf("vec%0d_writeData", k), writeData_out, vec[k].e_wdata);
         chk($sformatf("vec%0d_reg1Busy", k), reg1Busy_out, vec[k].e_busy);
         chk($sformatf("vec%0d_reg2Busy", k), reg2Busy_out, vec[k].e_busy);
         chk($sformatf("vec%0d_issueReady", k), issueReady_out, vec[k].e_irdy);
         next_cycle();
      end

      // Sustained contention for 4 cycles, then drain
      do_reset();
      for (int k = 0; k < 5; k++) begin
         bit exp_a;
         bit prev_a;
         idle();
         if (k < 4) begin
            aValid_in = 1'b1; aIdx_in = 5'd10; aData_in = 32'hA0 + k;
            bValid_in = 1'b1; bIdx_in = 5'd11; bData_in = 32'hB0 + k;
         end
`ifdef REGWB_RR_ARB_EN
         exp_a  = (k % 2) == 0;
         prev_a = ((k - 1) % 2) == 0;
`else
         exp_a  = 1'b0;
         prev_a = 1'b0;
`endif
         #3;
         if (k < 4) begin
            chk($sformatf("tie%0d_aReady", k), aReady_out, exp_a);
            chk($sformatf("tie%0d_bReady", k), bReady_out, !exp_a);
         end
         if (k > 0) begin
            chk($sformatf("tie%0d_writeE", k), writeE_out, 1'b1);
            chk($sformatf("tie%0d_writeIdx", k), writeIdx_out, prev_a ? 5'd10 : 5'd11);
            chk($sformatf("tie%0d_writeData", k), writeData_out,
                prev_a ? (32'hA0 + k - 1) : (32'hB0 + k - 1));
         end
         next_cycle();
      end

      // Flush with an entry going in flight on the same edge
      do_reset();
      issueE_in = 1'b1; issueIdx_in = 5'd2;
      next_cycle();
      issueIdx_in = 5'd9;
      next_cycle();
      idle();
      aValid_in = 1'b1; aIdx_in = 5'd12; aData_in = 32'hC0DE; flush_in = 1'b1;
      reg1Idx_in = 5'd2; reg2Idx_in = 5'd9;
      #3;
      chk("flush_pre_reg1Busy", reg1Busy_out, 1'b1);
      chk("flush_pre_reg2Busy", reg2Busy_out, 1'b1);
      next_cycle();
      aValid_in = 1'b0; flush_in = 1'b0;
      #3;
      chk("flush_writeE", writeE_out, 1'b1);
      chk("flush_writeIdx", writeIdx_out, 5'd12);
      chk("flush_writeData", writeData_out, 32'hC0DE);
      chk("flush_reg1Busy", reg1Busy_out, 1'b0);
      chk("flush_reg2Busy", reg2Busy_out, 1'b0);
      next_cycle();

      // Reset instead of flush drops the in-flight entry
      issueE_in = 1'b1; issueIdx_in = 5'd2;
      next_cycle();
      idle();
      reg1Idx_in = 5'd2; issueIdx_in = 5'd2;
      #3;
      chk("rstmid_pre_busy", reg1Busy_out, 1'b1);
      aValid_in = 1'b1; aIdx_in = 5'd13; aData_in = 32'hD00D; rst_in = 1'b0;
      next_cycle();
      rst_in = 1'b1; aValid_in = 1'b0;
      #3;
      chk("rstmid_writeE", writeE_out, 1'b0);
      chk("rstmid_writeIdx", writeIdx_out, 5'd0);
      chk("rstmid_writeData", writeData_out, 32'h0);
      chk("rstmid_reg1Busy", reg1Busy_out, 1'b0);
      chk("rstmid_issueReady", issueReady_out, 1'b1);
      next_cycle();

      // Randomized phase against the model
      do_reset();
      model_reset();
      for (int k = 0; k < 400; k++) begin
         aValid_in   = $urandom_range(0, 1);
         aIdx_in     = 5'($urandom_range(0, 7));
         aData_in    = $urandom;
         bValid_in   = $urandom_range(0, 1);
         bIdx_in     = 5'($urandom_range(0, 7));
         bData_in    = $urandom;
         issueE_in   = $urandom_range(0, 1);
         issueIdx_in = 5'($urandom_range(0, 7));
         reg1Idx_in  = 5'($urandom_range(0, 7));
         reg2Idx_in  = 5'($urandom_range(0, 7));
         flush_in    = ($urandom_range(0, 19) == 0);
         #3;
         check_model();
         model_step();
         next_cycle();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
